// File: rtl/gain_pkg.sv
// Shared constants and helpers for gain_shift_pipe.
// Build option: define GAIN_SHIFT_PIPE_ROUND_EN to round half up before the shift; otherwise truncate.
package gain_pkg;

`ifdef GAIN_SHIFT_PIPE_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int SAT_CNT_W = 16;

  function automatic int unsigned unity_gain(input int unsigned shift);
    return 32'd1 << shift;
  endfunction

  function automatic int unsigned round_term(input int unsigned shift);
    return ROUND_EN ? (32'd1 << (shift - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/gain_shift_pipe_if.sv
// Pixel stream handshake bundle: input side (in_*) and output side (out_*).
interface gain_shift_pipe_if #(
  parameter int WIDTH = 12,
  parameter int LANES = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_pix;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   out_pix;
  logic [LANES-1:0]         out_sat;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_pix, out_sat
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_pix, out_sat
  );
endinterface

// File: rtl/gain_lane.sv
// One lane datapath: multiply (S1->S2) and round/shift/saturate (S2->S3), purely combinational.
module gain_lane
  import gain_pkg::*;
#(
  parameter int  WIDTH  = 12,
  parameter int  GAIN_W = 12,
  parameter int  SHIFT  = 8,
  localparam int PW     = WIDTH + GAIN_W
) (
  input  logic [WIDTH-1:0]  pix_i,
  input  logic [GAIN_W-1:0] gain_i,
  output logic [PW-1:0]     prod_o,
  input  logic [PW-1:0]     prod_i,
  output logic [WIDTH-1:0]  res_o,
  output logic              sat_o
);
  localparam logic [PW-1:0] RND = PW'(round_term(SHIFT));

  logic [PW-1:0] rounded;
  logic [PW-1:0] shifted;

  multiplier #(.A_W(WIDTH), .B_W(GAIN_W)) u_mul (
    .a_i (pix_i),
    .b_i (gain_i),
    .p_o (prod_o)
  );

  // Largest product plus the half-LSB term still fits in PW bits since SHIFT < GAIN_W.
  assign rounded = prod_i + RND;

  right_shifter #(.W(PW), .SH(SHIFT)) u_shr (
    .x_i (rounded),
    .y_o (shifted)
  );

  assign sat_o = |shifted[PW-1:WIDTH];
  assign res_o = sat_o ? '1 : shifted[WIDTH-1:0];
endmodule

// File: rtl/multiplier.sv
// Unsigned full-width multiplier primitive.
module multiplier #(
  parameter int A_W = 12,
  parameter int B_W = 12
) (
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  output logic [A_W+B_W-1:0] p_o
);
  assign p_o = {{B_W{1'b0}}, a_i} * {{A_W{1'b0}}, b_i};
endmodule

// File: rtl/right_shifter.sv
// Constant logical right shift primitive; output keeps the input width.
module right_shifter #(
  parameter int W  = 24,
  parameter int SH = 8
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);
  assign y_o = x_i >> SH;
endmodule

// File: rtl/gain_shift_pipe.sv
// Three-stage per-lane gain pipeline with saturation flags and a saturation counter.
// Rounding is selected by GAIN_SHIFT_PIPE_ROUND_EN (see gain_pkg).
module gain_shift_pipe
  import gain_pkg::*;
#(
  parameter int  WIDTH  = 12,
  parameter int  GAIN_W = 12,
  parameter int  SHIFT  = 8,
  parameter int  LANES  = 3,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gain_shift_pipe_if.slave     bus,
  input  logic                 gain_we,
  input  logic [LANE_W-1:0]    gain_lane,
  input  logic [GAIN_W-1:0]    gain_data,
  output logic [SAT_CNT_W-1:0] sat_cnt,
  input  logic                 sat_clr
);
  localparam int PW = WIDTH + GAIN_W;

  logic [GAIN_W-1:0]    gain_q    [LANES];
  logic                 s1_valid_q, s2_valid_q, s3_valid_q;
  logic [WIDTH-1:0]     s1_pix_q  [LANES];
  logic [GAIN_W-1:0]    s1_gain_q [LANES];
  logic [PW-1:0]        s2_prod_q [LANES];
  logic [WIDTH-1:0]     s3_pix_q  [LANES];
  logic [LANES-1:0]     s3_sat_q;
  logic [PW-1:0]        prod_d    [LANES];
  logic [WIDTH-1:0]     res_d     [LANES];
  logic [LANES-1:0]     sat_d;
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic [SAT_CNT_W:0]   sat_pop, sat_sum;
  logic                 adv1, adv2, adv3, out_fire, gain_hit;

  // Each stage moves when the one after it is empty or moving.
  assign adv3     = !s3_valid_q || bus.out_ready;
  assign adv2     = !s2_valid_q || adv3;
  assign adv1     = !s1_valid_q || adv2;
  assign out_fire = s3_valid_q && bus.out_ready;
  assign gain_hit = gain_we && ({1'b0, gain_lane} < (LANE_W+1)'(LANES));

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s3_valid_q;
  assign bus.out_sat   = s3_sat_q;
  assign sat_cnt       = sat_cnt_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gain_lane #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .SHIFT(SHIFT)) u_lane (
      .pix_i  (s1_pix_q[g]),
      .gain_i (s1_gain_q[g]),
      .prod_o (prod_d[g]),
      .prod_i (s2_prod_q[g]),
      .res_o  (res_d[g]),
      .sat_o  (sat_d[g])
    );
    assign bus.out_pix[g*WIDTH +: WIDTH] = s3_pix_q[g];
  end

  always_comb begin
    sat_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sat_pop = sat_pop + (SAT_CNT_W+1)'(s3_sat_q[i]);
    end
    sat_sum   = {1'b0, sat_cnt_q} + sat_pop;
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_fire) begin
      sat_cnt_d = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_sat_q   <= '0;
      sat_cnt_q  <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        gain_q[i]    <= GAIN_W'(unity_gain(SHIFT));
        s1_pix_q[i]  <= '0;
        s1_gain_q[i] <= '0;
        s2_prod_q[i] <= '0;
        s3_pix_q[i]  <= '0;
      end
    end else begin
      // Snapshot takes the pre-write gain, so a same-edge write only affects later pixels.
      if (adv1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            s1_pix_q[i]  <= bus.in_pix[i*WIDTH +: WIDTH];
            s1_gain_q[i] <= gain_q[i];
          end
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_prod_q <= prod_d;
      end
      if (adv3) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_pix_q <= res_d;
          s3_sat_q <= sat_d;
        end
      end
      if (gain_hit) gain_q[gain_lane] <= gain_data;
      sat_cnt_q <= sat_cnt_d;
    end
  end
endmodule

// File: tb/tb_gain_shift_pipe.sv
// Self-checking bench for gain_shift_pipe: directed literal cases plus randomized traffic against a queue model.
module tb_gain_shift_pipe;
  localparam int W  = 12;
  localparam int G  = 12;
  localparam int SH = 8;
  localparam int L  = 3;
`ifdef GAIN_SHIFT_PIPE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [L*W-1:0] pix;
    logic [L-1:0]   sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gain_we = 1'b0;
  logic [1:0]  gain_lane = '0;
  logic [G-1:0] gain_data = '0;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;

  gain_shift_pipe_if #(.WIDTH(W), .LANES(L)) bus ();

  gain_shift_pipe #(.WIDTH(W), .GAIN_W(G), .SHIFT(SH), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gain_we   (gain_we),
    .gain_lane (gain_lane),
    .gain_data (gain_data),
    .sat_cnt   (sat_cnt),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  function automatic void chk(input string name, input longint unsigned act, input longint unsigned exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference model state, advanced once per cycle by the monitor.
  exp_t            q[$];
  int unsigned     m_gain [L];
  int unsigned     m_sat;
  int unsigned     delivered = 0;
  logic            prev_stall = 1'b0;
  logic [L*W-1:0]  prev_pix;
  logic [L-1:0]    prev_sat;
  exp_t            mon_e;
  int unsigned     mon_inc;

  function automatic exp_t model(input logic [L*W-1:0] p);
    exp_t e;
    longint unsigned v;
    for (int i = 0; i < L; i++) begin
      v = longint'(p[i*W +: W]) * m_gain[i];
      if (RND) v = v + 128;
      v = v / 256;
      if (v > 4095) begin
        e.pix[i*W +: W] = 12'hFFF;
        e.sat[i] = 1'b1;
      end else begin
        e.pix[i*W +: W] = v[11:0];
        e.sat[i] = 1'b0;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_sat = 0;
      for (int i = 0; i < L; i++) m_gain[i] = 256;
      prev_stall = 1'b0;
    end else begin
      chk("sat_cnt", sat_cnt, m_sat);
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_pix", bus.out_pix, prev_pix);
        chk("hold_sat", bus.out_sat, prev_sat);
      end
      mon_inc = 0;
      if (bus.out_valid && q.size() == 0) begin
        chk("spurious_out", bus.out_valid, 0);
      end else if (bus.out_valid && bus.out_ready) begin
        mon_e = q.pop_front();
        chk("out_pix", bus.out_pix, mon_e.pix);
        chk("out_sat", bus.out_sat, mon_e.sat);
        delivered++;
        mon_inc = $countones(mon_e.sat);
      end
      if (sat_clr) m_sat = 0;
      else m_sat = (m_sat + mon_inc > 65535) ? 65535 : m_sat + mon_inc;
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_pix));
      if (gain_we && gain_lane < L) m_gain[gain_lane] = gain_data;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pix;
      prev_sat   = bus.out_sat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input logic [L*W-1:0] pix, input logic we, input logic [1:0] lane,
                          input logic [G-1:0] data);
    logic rdy;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_pix   = pix;
    gain_we      = we;
    gain_lane    = lane;
    gain_data    = data;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      tick();
      if (rdy) break;
      n++;
      if (n >= 200) begin
        chk("push_timeout", rdy, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
    gain_we      = 1'b0;
  endtask

  task automatic send_check(input string name, input logic [L*W-1:0] pix, input logic we,
                            input logic [1:0] lane, input logic [G-1:0] data,
                            input logic [L*W-1:0] exp_pix, input logic [L-1:0] exp_sat);
    tick();
    bus.out_ready = 1'b1;
    push_pix(pix, we, lane, data);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_early"}, bus.out_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_pix"}, bus.out_pix, exp_pix);
    chk({name, "_sat"}, bus.out_sat, exp_sat);
  endtask

  task automatic write_gain(input logic [1:0] lane, input logic [G-1:0] data);
    tick();
    gain_we   = 1'b1;
    gain_lane = lane;
    gain_data = data;
    tick();
    gain_we   = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pix", bus.out_pix, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    send_check("unity", {12'd100, 12'd100, 12'd100}, 1'b0, 2'd0, '0,
               {12'd100, 12'd100, 12'd100}, 3'b000);

    write_gain(2'd0, 12'h180);
    write_gain(2'd1, 12'h080);
    write_gain(2'd2, 12'h200);
    send_check("gains", {12'hFFF, 12'd3, 12'd100}, 1'b0, 2'd0, '0,
               {12'hFFF, (RND ? 12'd2 : 12'd1), 12'd150}, 3'b100);
    tick();
    chk("sat_cnt_one", sat_cnt, 1);

    send_check("wr_same", {12'd0, 12'd0, 12'd100}, 1'b1, 2'd0, 12'h200,
               {12'd0, 12'd0, 12'd150}, 3'b000);
    send_check("wr_next", {12'd0, 12'd0, 12'd100}, 1'b0, 2'd0, '0,
               {12'd0, 12'd0, 12'd200}, 3'b000);
    send_check("wr_lane3", {12'd1, 12'd4, 12'd100}, 1'b1, 2'd3, 12'h000,
               {12'd2, 12'd2, 12'd200}, 3'b000);
    send_check("wr_lane3_after", {12'd1, 12'd4, 12'd100}, 1'b0, 2'd0, '0,
               {12'd2, 12'd2, 12'd200}, 3'b000);

    // Eight-pixel stream with a three-cycle downstream stall once the pipe is full.
    tick();
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 8; i++) push_pix(36'({$urandom(), $urandom()}) & 36'h7FF_7FF_7FF, 1'b0, 2'd0, '0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("full_in_ready", bus.in_ready, 0);
          tick();
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    chk("stream_drained", q.size(), 0);
    chk("stream_count", delivered - d0, 8);

    repeat (3000) begin
      tick();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_pix    = 36'({$urandom(), $urandom()});
      bus.out_ready = ($urandom_range(0, 3) != 0);
      gain_we       = ($urandom_range(0, 9) == 0);
      gain_lane     = 2'($urandom_range(0, 3));
      gain_data     = 12'($urandom_range(0, 12'h3FF));
      sat_clr       = ($urandom_range(0, 49) == 0);
    end
    tick();
    bus.in_valid  = 1'b0;
    gain_we       = 1'b0;
    sat_clr       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("random_drained", q.size(), 0);

    // Drive sat_cnt into its ceiling, confirm it holds, then clear during a saturating handshake.
    write_gain(2'd0, 12'hFFF);
    write_gain(2'd1, 12'hFFF);
    write_gain(2'd2, 12'hFFF);
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    for (int i = 0; i < 21846; i++) push_pix(36'hFFF_FFF_FFF, 1'b0, 2'd0, '0);
    repeat (5) tick();
    chk("sat_cnt_max", sat_cnt, 16'hFFFF);
    for (int i = 0; i < 2; i++) push_pix(36'hFFF_FFF_FFF, 1'b0, 2'd0, '0);
    repeat (5) tick();
    chk("sat_cnt_hold", sat_cnt, 16'hFFFF);
    fork
      begin
        for (int i = 0; i < 8; i++) push_pix(36'hFFF_FFF_FFF, 1'b0, 2'd0, '0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sat_clr_zero", sat_cnt, 0);
      end
    join
    repeat (6) tick();

    // Reset with three pixels in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pix(36'h123_456_789, 1'b0, 2'd0, '0);
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sat_cnt", sat_cnt, 0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", bus.out_valid, 0);
    end
    send_check("post_rst_unity", {12'd4095, 12'd7, 12'd100}, 1'b0, 2'd0, '0,
               {12'd4095, 12'd7, 12'd100}, 3'b000);
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
